// File: rtl/alu_pipe_pkg.sv
// Shared types, command encodings and decode helpers for alu_pipe_core.
package alu_pipe_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CMD_WIDTH = 4;
    localparam int DEF_TIMEOUT   = 16;
    localparam int DEF_MUL_LAT   = 2;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND    = 4'd0,
        L_NAND   = 4'd1,
        L_OR     = 4'd2,
        L_NOR    = 4'd3,
        L_XOR    = 4'd4,
        L_XNOR   = 4'd5,
        L_NOT_A  = 4'd6,
        L_NOT_B  = 4'd7,
        L_SHR1_A = 4'd8,
        L_SHL1_A = 4'd9,
        L_SHR1_B = 4'd10,
        L_SHL1_B = 4'd11,
        L_ROL_AB = 4'd12,
        L_ROR_AB = 4'd13
    } logic_cmd_e;

    typedef logic [1:0] state_e;
    localparam state_e S_IDLE    = 2'd0;
    localparam state_e S_WAIT_OP = 2'd1;
    localparam state_e S_EXEC    = 2'd2;
    localparam state_e S_MUL     = 2'd3;

    function automatic logic is_legal(input logic mode, input logic [3:0] cmd);
        return mode ? (cmd <= 4'd10) : (cmd <= 4'd13);
    endfunction

    function automatic logic is_unary(input logic mode, input logic [3:0] cmd);
        return mode ? (cmd inside {A_INC_A, A_DEC_A, A_INC_B, A_DEC_B})
                    : (cmd inside {L_NOT_A, L_NOT_B, L_SHR1_A, L_SHL1_A, L_SHR1_B, L_SHL1_B});
    endfunction

    // Which operand a unary command consumes (1 = OPB).
    function automatic logic unary_on_b(input logic mode, input logic [3:0] cmd);
        return mode ? (cmd inside {A_INC_B, A_DEC_B})
                    : (cmd inside {L_NOT_B, L_SHR1_B, L_SHL1_B});
    endfunction

    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && (cmd inside {A_MUL_INC, A_MUL_SHL});
    endfunction

endpackage

// File: rtl/alu_pipe_core_mul.sv
// Register-staged multiplier: product formed into stage 1, then delayed to MUL_LAT stages.
module alu_mul_pipe #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_vld,
    input  logic [WIDTH:0]       a,
    input  logic [WIDTH:0]       b,
    output logic                 out_vld,
    output logic [2*WIDTH-1:0]   prod
);

    logic [2*WIDTH-1:0]                prod0;
    logic [MUL_LAT:1]                  vld_pipe;
    logic [MUL_LAT:1][2*WIDTH-1:0]     prod_pipe;

    // Operands are WIDTH+1 wide; the product is truncated to the 2*WIDTH result.
    assign prod0 = {{(WIDTH-1){1'b0}}, a} * {{(WIDTH-1){1'b0}}, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            prod_pipe <= '0;
        end else if (ce) begin
            vld_pipe[1]  <= in_vld;
            prod_pipe[1] <= prod0;
            for (int i = 2; i <= MUL_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                prod_pipe[i] <= prod_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[MUL_LAT];
    assign prod    = prod_pipe[MUL_LAT];

endmodule

// File: rtl/alu_pipe_core.sv
// Pipelined ALU with split-operand capture, timeout and multi-cycle multiply.
// Define ALU_SAT_EN for saturating add/sub/inc/dec instead of wrap-around.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CMD_WIDTH = DEF_CMD_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MUL_LAT   = DEF_MUL_LAT
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [1:0]            INP_VALID,
    input  logic                  MODE,
    input  logic [CMD_WIDTH-1:0]  CMD,
    input  logic [WIDTH-1:0]      OPA,
    input  logic [WIDTH-1:0]      OPB,
    input  logic                  CIN,
    output logic [2*WIDTH-1:0]    RES,
    output logic                  OUT_VALID,
    output logic                  COUT,
    output logic                  OFLOW,
    output logic                  G,
    output logic                  L,
    output logic                  E,
    output logic                  ERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(WIDTH);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

    typedef struct packed {
        logic [2*WIDTH-1:0] res;
        logic               cout;
        logic               oflow;
        logic               g;
        logic               l;
        logic               e;
        logic               err;
    } resp_t;

    localparam resp_t TO_RESP = resp_t'({{(2*WIDTH){1'b0}}, 6'b000001});

    state_e              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    cap_a, cap_b;
    logic [3:0]          cap_cmd;
    logic                cap_hi, cap_mode, cap_cin;
    logic [1:0]          miss;
    resp_t               out_q, alu_r, mul_r;
    logic                out_valid_q;

    // Commands wider than 4 bits are legal only with zero upper bits.
    logic [3:0] in_cmd4;
    logic       in_hi;
    assign in_cmd4 = CMD[3:0];
    if (CMD_WIDTH > 4) begin : g_cmd_hi
        assign in_hi = |CMD[CMD_WIDTH-1:4];
    end else begin : g_cmd_lo
        assign in_hi = 1'b0;
    end

    logic in_legal, in_un, in_need, go_exec, cap_legal, exec_mul;
    assign in_legal  = !in_hi && is_legal(MODE, in_cmd4);
    assign in_un     = is_unary(MODE, in_cmd4);
    assign in_need   = unary_on_b(MODE, in_cmd4) ? INP_VALID[1] : INP_VALID[0];
    assign go_exec   = !in_legal || (INP_VALID == 2'b11) || (in_un && in_need);
    assign cap_legal = !cap_hi && is_legal(cap_mode, cap_cmd);
    assign exec_mul  = cap_legal && is_mul(cap_mode, cap_cmd);

    // Multiplier operand preparation: (A+1)*(B+1) or (A<<1)*B.
    logic [WIDTH:0] mul_a, mul_b;
    logic           mul_vld;
    logic [2*WIDTH-1:0] mul_prod;
    assign mul_a = (cap_cmd == A_MUL_INC) ? ({1'b0, cap_a} + ONE) : {cap_a, 1'b0};
    assign mul_b = (cap_cmd == A_MUL_INC) ? ({1'b0, cap_b} + ONE) : {1'b0, cap_b};

    alu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .rst     (RST),
        .ce      (CE),
        .in_vld  ((state == S_EXEC) && exec_mul),
        .a       (mul_a),
        .b       (mul_b),
        .out_vld (mul_vld),
        .prod    (mul_prod)
    );

    always_comb begin
        mul_r     = '0;
        mul_r.res = mul_prod;
    end

    logic [WIDTH:0]     sum;
    logic               add_t, sub_t, rot_bad;
    logic [WIDTH-1:0]   lres;
    logic [2*WIDTH-1:0] dbl;
    logic [SW-1:0]      rot_amt;

    always_comb begin
        alu_r   = '0;
        sum     = '0;
        add_t   = 1'b0;
        sub_t   = 1'b0;
        lres    = '0;
        dbl     = {cap_a, cap_a};
        rot_amt = cap_b[SW-1:0];
        rot_bad = |(cap_b >> SW);
        if (!cap_legal) begin
            alu_r.err = 1'b1;
        end else if (cap_mode) begin
            case (cap_cmd)
                A_ADD:     begin sum = {1'b0, cap_a} + {1'b0, cap_b}; add_t = 1'b1; end
                A_SUB:     begin sum = {1'b0, cap_a} - {1'b0, cap_b}; sub_t = 1'b1; end
                A_ADD_CIN: begin sum = {1'b0, cap_a} + {1'b0, cap_b} + {{WIDTH{1'b0}}, cap_cin}; add_t = 1'b1; end
                A_SUB_CIN: begin sum = {1'b0, cap_a} - {1'b0, cap_b} - {{WIDTH{1'b0}}, cap_cin}; sub_t = 1'b1; end
                A_INC_A:   begin sum = {1'b0, cap_a} + ONE; add_t = 1'b1; end
                A_DEC_A:   begin sum = {1'b0, cap_a} - ONE; sub_t = 1'b1; end
                A_INC_B:   begin sum = {1'b0, cap_b} + ONE; add_t = 1'b1; end
                A_DEC_B:   begin sum = {1'b0, cap_b} - ONE; sub_t = 1'b1; end
                A_CMP: begin
                    alu_r.g = cap_a > cap_b;
                    alu_r.l = cap_a < cap_b;
                    alu_r.e = cap_a == cap_b;
                end
                default: ;
            endcase
            // sum[WIDTH] is carry for adds and borrow for subtracts.
            if (add_t || sub_t) begin
`ifdef ALU_SAT_EN
                if (sum[WIDTH]) begin
                    alu_r.res   = add_t ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : '0;
                    alu_r.oflow = 1'b1;
                end else begin
                    alu_r.res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                end
`else
                alu_r.res   = {{(WIDTH-1){1'b0}}, sum};
                alu_r.cout  = sum[WIDTH];
                alu_r.oflow = sub_t && sum[WIDTH];
`endif
            end
        end else begin
            case (cap_cmd)
                L_AND:    lres = cap_a & cap_b;
                L_NAND:   lres = ~(cap_a & cap_b);
                L_OR:     lres = cap_a | cap_b;
                L_NOR:    lres = ~(cap_a | cap_b);
                L_XOR:    lres = cap_a ^ cap_b;
                L_XNOR:   lres = ~(cap_a ^ cap_b);
                L_NOT_A:  lres = ~cap_a;
                L_NOT_B:  lres = ~cap_b;
                L_SHR1_A: lres = cap_a >> 1;
                L_SHL1_A: lres = cap_a << 1;
                L_SHR1_B: lres = cap_b >> 1;
                L_SHL1_B: lres = cap_b << 1;
                L_ROL_AB: lres = rot_bad ? '0 : WIDTH'((dbl << rot_amt) >> WIDTH);
                L_ROR_AB: lres = rot_bad ? '0 : WIDTH'(dbl >> rot_amt);
                default:  lres = '0;
            endcase
            alu_r.err = (cap_cmd inside {L_ROL_AB, L_ROR_AB}) && rot_bad;
            alu_r.res = {{WIDTH{1'b0}}, lres};
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cap_a       <= '0;
            cap_b       <= '0;
            cap_cmd     <= '0;
            cap_hi      <= 1'b0;
            cap_mode    <= 1'b0;
            cap_cin     <= 1'b0;
            miss        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (CE) begin
            out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (INP_VALID != 2'b00 && (go_exec || !in_un)) begin
                        cap_a    <= OPA;
                        cap_b    <= OPB;
                        cap_cmd  <= in_cmd4;
                        cap_hi   <= in_hi;
                        cap_mode <= MODE;
                        cap_cin  <= CIN;
                        cnt      <= '0;
                        miss     <= ~INP_VALID;
                        state    <= go_exec ? S_EXEC : S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if ((INP_VALID & miss) != 2'b00) begin
                        if (miss[0]) cap_a <= OPA;
                        else         cap_b <= OPB;
                        state <= S_EXEC;
                    end else if (cnt == TO_LAST) begin
                        out_q       <= TO_RESP;
                        out_valid_q <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_mul) begin
                        state <= S_MUL;
                    end else begin
                        out_q       <= alu_r;
                        out_valid_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (mul_vld) begin
                        out_q       <= mul_r;
                        out_valid_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign RES       = out_q.res;
    assign COUT      = out_q.cout;
    assign OFLOW     = out_q.oflow;
    assign G         = out_q.g;
    assign L         = out_q.l;
    assign E         = out_q.e;
    assign ERR       = out_q.err;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed bench for alu_pipe_core at WIDTH=8, TIMEOUT=16, MUL_LAT=2.
module tb_alu_pipe_core;

    localparam int W = 8;

    logic           clk, RST, CE, MODE, CIN;
    logic [1:0]     INP_VALID;
    logic [3:0]     CMD;
    logic [W-1:0]   OPA, OPB;
    logic [2*W-1:0] RES;
    logic           OUT_VALID, COUT, OFLOW, G, L, E, ERR;

    int n_vec = 0;
    int n_bad = 0;
    int lat;

    alu_pipe_core #(.WIDTH(W), .CMD_WIDTH(4), .TIMEOUT(16), .MUL_LAT(2)) dut (
        .clk(clk), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES),
        .OUT_VALID(OUT_VALID), .COUT(COUT), .OFLOW(OFLOW),
        .G(G), .L(L), .E(E), .ERR(ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation for a single capture edge, then drop INP_VALID.
    task automatic issue(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        MODE = m; CMD = c; INP_VALID = v; OPA = a; OPB = b; CIN = ci;
        tick();
        INP_VALID = 2'b00;
    endtask

    task automatic run_ov(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (OUT_VALID) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] r, input logic co,
                           input logic of, input logic er);
        chk({tag, "_res"},  64'(RES),   64'(r));
        chk({tag, "_cout"}, 64'(COUT),  64'(co));
        chk({tag, "_ofl"},  64'(OFLOW), 64'(of));
        chk({tag, "_err"},  64'(ERR),   64'(er));
    endtask

    initial begin
        RST = 1'b1; CE = 1'b1; INP_VALID = 2'b00; MODE = 1'b0; CMD = 4'd0;
        OPA = '0; OPB = '0; CIN = 1'b0;
        #3;
        chk("rst_ov", 64'(OUT_VALID), 64'd0);
        chk_res("rst", 16'd0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // ADD 200+100, latency 1, strobe lasts one cycle
        issue(1'b1, 4'd0, 2'b11, 8'd200, 8'd100, 1'b0);
        chk("add_ov_exec", 64'(OUT_VALID), 64'd0);
        run_ov(8, lat);
        chk("add_lat", 64'(lat), 64'd1);
        chk_res("add", 16'h012C, 1'b1, 1'b0, 1'b0);
        tick();
        chk("add_strobe", 64'(OUT_VALID), 64'd0);

        // MUL_INC (3+1)*(4+1)
        issue(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
        run_ov(10, lat);
        chk("mulinc_lat", 64'(lat), 64'd3);
        chk_res("mulinc", 16'd20, 1'b0, 1'b0, 1'b0);

        // MUL_SHL (200<<1)*100
        issue(1'b1, 4'd10, 2'b11, 8'd200, 8'd100, 1'b0);
        run_ov(10, lat);
        chk("mulshl_lat", 64'(lat), 64'd3);
        chk("mulshl_res", 64'(RES), 64'd40000);

        // ADD_CIN split capture; CMD change while waiting is ignored
        issue(1'b1, 4'd2, 2'b01, 8'd5, 8'd0, 1'b1);
        CMD = 4'd1; CIN = 1'b0;
        tick(); tick(); tick();
        chk("split_wait_ov", 64'(OUT_VALID), 64'd0);
        OPB = 8'd6; INP_VALID = 2'b10;
        tick();
        INP_VALID = 2'b00;
        run_ov(8, lat);
        chk("split_lat", 64'(lat), 64'd1);
        chk_res("split", 16'd12, 1'b0, 1'b0, 1'b0);

        // AND with OPB never arriving: timeout
        issue(1'b0, 4'd0, 2'b01, 8'hF0, 8'h00, 1'b0);
        run_ov(40, lat);
        chk("to_lat", 64'(lat), 64'd16);
        chk_res("to", 16'd0, 1'b0, 1'b0, 1'b1);

        // Reset during multiply: outputs clear at once, no result follows
        issue(1'b1, 4'd10, 2'b11, 8'd5, 8'd3, 1'b0);
        tick();
        RST = 1'b1;
        #2;
        chk("rstmul_err", 64'(ERR), 64'd0);
        chk("rstmul_ov", 64'(OUT_VALID), 64'd0);
        RST = 1'b0;
        run_ov(8, lat);
        chk("rstmul_noov", 64'(lat), {64{1'b1}});
        issue(1'b1, 4'd0, 2'b11, 8'd1, 8'd1, 1'b0);
        run_ov(8, lat);
        chk("post_rst_lat", 64'(lat), 64'd1);
        chk_res("post_rst", 16'd2, 1'b0, 1'b0, 1'b0);

        // Logical ops and rotate error
        issue(1'b0, 4'd4, 2'b11, 8'hA5, 8'h0F, 1'b0);
        run_ov(8, lat);
        chk("xor_res", 64'(RES), 64'hAA);
        issue(1'b0, 4'd6, 2'b01, 8'h5A, 8'h00, 1'b0);
        run_ov(8, lat);
        chk("nota_lat", 64'(lat), 64'd1);
        chk("nota_res", 64'(RES), 64'hA5);
        issue(1'b0, 4'd12, 2'b11, 8'h81, 8'd1, 1'b0);
        run_ov(8, lat);
        chk("rol_res", 64'(RES), 64'h03);
        issue(1'b0, 4'd13, 2'b11, 8'h81, 8'd1, 1'b0);
        run_ov(8, lat);
        chk("ror_res", 64'(RES), 64'hC0);
        issue(1'b0, 4'd13, 2'b11, 8'h81, 8'd8, 1'b0);
        run_ov(8, lat);
        chk_res("ror_bad", 16'd0, 1'b0, 1'b0, 1'b1);

        // CMP sets only compare flags; next arithmetic op clears them
        issue(1'b1, 4'd8, 2'b11, 8'd7, 8'd9, 1'b0);
        run_ov(8, lat);
        chk("cmp_res", 64'(RES), 64'd0);
        chk("cmp_glе", 64'({G, L, E}), 64'b010);

        // Illegal command
        issue(1'b1, 4'd12, 2'b11, 8'd1, 8'd2, 1'b0);
        run_ov(8, lat);
        chk("ill_lat", 64'(lat), 64'd1);
        chk_res("ill", 16'd0, 1'b0, 1'b0, 1'b1);

        // SUB 3-5 and ADD 250+10: wrap or saturate depending on build
        issue(1'b1, 4'd1, 2'b11, 8'd3, 8'd5, 1'b0);
        run_ov(8, lat);
`ifdef ALU_SAT_EN
        chk_res("sub", 16'd0, 1'b0, 1'b1, 1'b0);
`else
        chk_res("sub", 16'h01FE, 1'b1, 1'b1, 1'b0);
`endif
        chk("sub_glе", 64'({G, L, E}), 64'b000);
        issue(1'b1, 4'd0, 2'b11, 8'd250, 8'd10, 1'b0);
        run_ov(8, lat);
`ifdef ALU_SAT_EN
        chk_res("sat_add", 16'd255, 1'b0, 1'b1, 1'b0);
`else
        chk_res("wrap_add", 16'h0104, 1'b1, 1'b0, 1'b0);
`endif

        // Back-to-back: capture in the OUT_VALID cycle
        issue(1'b1, 4'd0, 2'b11, 8'd10, 8'd20, 1'b0);
        tick();
        chk("b2b_ov1", 64'(OUT_VALID), 64'd1);
        chk("b2b_res1", 64'(RES), 64'd30);
        issue(1'b1, 4'd0, 2'b11, 8'd1, 8'd2, 1'b0);
        chk("b2b_ov_gap", 64'(OUT_VALID), 64'd0);
        tick();
        chk("b2b_ov2", 64'(OUT_VALID), 64'd1);
        chk("b2b_res2", 64'(RES), 64'd3);

        // CE low for 3 cycles mid-multiply stretches latency by 3
        issue(1'b1, 4'd9, 2'b11, 8'd2, 8'd2, 1'b0);
        tick();
        CE = 1'b0;
        tick(); tick(); tick();
        chk("ce_frozen_ov", 64'(OUT_VALID), 64'd0);
        CE = 1'b1;
        run_ov(10, lat);
        chk("ce_total_lat", 64'(1 + 3 + lat), 64'd6);
        chk("ce_res", 64'(RES), 64'd9);
        CE = 1'b0;
        tick();
        chk("ce_hold_ov", 64'(OUT_VALID), 64'd1);
        CE = 1'b1;
        tick();
        chk("ce_release_ov", 64'(OUT_VALID), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe_core.md
Name: alu_pipe_core

Overview:
- Parametrised, pipelined successor to the team's 8-bit ALU.
- Operand width, command width and timeout are configurable.
- New behaviour:
  - operands A and B may arrive in different cycles, collected under a timeout;
  - multi-cycle multiply ops;
  - explicit OUT_VALID strobe on every result.
- Sits between the stimulus/driver-facing operand bus and result consumers. Same CE/MODE/CMD/INP_VALID contract as the previous generation.

Parameters:
- WIDTH, 8, operand width in bits (>=4).
- CMD_WIDTH, 4, command field width.
- TIMEOUT, 16, max cycles waiting for the missing operand before ERR.
- MUL_LAT, 2, extra pipeline stages for multiply commands (>=1).

Ports:
- clk  in  1  clock
- RST  in  1  reset
- CE  in  1  clock enable; low freezes all state and outputs
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- MODE  in  1  1 = arithmetic, 0 = logical
- CMD  in  CMD_WIDTH  operation select
- OPA, OPB  in  WIDTH  operands
- CIN  in  1  carry in
- RES  out  2*WIDTH  result
- OUT_VALID  out  1  one-cycle strobe, RES/flags valid
- COUT, OFLOW  out  1  carry out / signed-unsigned overflow
- G, L, E  out  1  compare flags
- ERR  out  1  illegal command, missing operand, or timeout

Interface: one clock, clk. RST is asynchronous, active-high: on assertion all outputs, FSM and counters go to 0 / IDLE immediately, with no clock needed.

Behaviour:
- Arithmetic commands (MODE=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP
  - 9 MUL_INC = (A+1)*(B+1); 10 MUL_SHL = (A<<1)*B
- Logical commands (MODE=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B: rotate amount = OPB[$clog2(WIDTH)-1:0]; OPB upper bits nonzero -> ERR, RES = 0
- Command classes:
  - Unary (INC/DEC_x, NOT_x, SHx_x) need only their own operand's valid bit.
  - All others are binary.
  - Unlisted CMD -> ERR.
- FSM states: IDLE, WAIT_OP, EXEC, MUL.
- IDLE (CE=1):
  - INP_VALID=11, or the unary's bit set -> capture, go to EXEC.
  - Binary cmd with only one bit set -> latch that operand plus CMD/MODE/CIN, go to WAIT_OP, counter = 0.
  - INP_VALID=00 -> stay.
- WAIT_OP:
  - Counter increments each CE cycle.
  - Missing bit arrives -> latch it, go to EXEC. The CMD/MODE at first capture are used; later CMD changes are ignored.
  - Counter reaches TIMEOUT-1 without the operand -> OUT_VALID=1, ERR=1, RES=0, return to IDLE.
- EXEC:
  - Non-multiply: registered result appears next cycle with OUT_VALID. Capture-to-OUT_VALID latency = 1 cycle. Returns to IDLE.
  - Multiply: go to MUL.
- MUL: MUL_LAT cycles, then OUT_VALID. Total multiply latency = 1+MUL_LAT. New inputs are ignored until return to IDLE. No ERR is raised for them; the bench must not drive them.
- Widths and flags:
  - Add/sub: RES[WIDTH:0] holds the sum, COUT = RES[WIDTH].
  - SUB: OFLOW = borrow (A<B).
  - Multiply: full 2*WIDTH product, COUT = OFLOW = 0.
  - CMP: only G/L/E are set (unsigned), RES = 0. Non-CMP ops clear G/L/E.
  - Logical ops zero-extend to 2*WIDTH.
- CE low in any state: the state, counter and outputs hold. OUT_VALID is held too; downstream qualifies it with CE.
- RST mid-WAIT_OP or mid-MUL: pending op is discarded, no OUT_VALID.
- Back-to-back: an op may be captured in IDLE on the cycle after OUT_VALID. Peak throughput is 1 op per 2 cycles.

Optional Feature:
- ALU_SAT_EN defined: ADD/ADD_CIN/INC clamp to {WIDTH{1'b1}}; SUB/SUB_CIN/DEC clamp to 0. OFLOW flags the clamp; COUT = 0.
- Undefined: wrap-around arithmetic with COUT as specified above.

Decomposition:
- Package alu_pipe_pkg holds:
  - arith_cmd_e and logic_cmd_e enums, state_e typedef;
  - is_unary() and is_mul() functions;
  - defaults for WIDTH/TIMEOUT/MUL_LAT.
- Sub-module alu_mul_pipe: parametrised WIDTH, MUL_LAT. Register-staged multiplier with valid shift chain and CE stall.

Test Plan (WIDTH=8, TIMEOUT=16, MUL_LAT=2):
- MODE=1, CMD=0, OPA=200, OPB=100, INP_VALID=11 -> 1 cycle later OUT_VALID=1, RES=300 (0x12C), COUT=1.
- MODE=1, CMD=9, OPA=3, OPB=4, INP_VALID=11 -> OUT_VALID exactly 3 cycles after capture, RES=20.
- CMD=2 with INP_VALID=01 (OPA=5), then after 4 cycles INP_VALID=10 (OPB=6), CIN=1 -> RES=12 one cycle after OPB capture.
- INP_VALID=01, binary AND, OPB never arrives -> ERR=1 with OUT_VALID exactly 16 cycles after capture, RES=0.
- MUL in flight, RST pulsed in stage 1 -> all outputs 0 immediately, no OUT_VALID follows. A following ADD 1+1 -> RES=2.
- With ALU_SAT_EN, ADD 250+10 -> RES=255, OFLOW=1. CE held low 3 cycles mid-MUL delays OUT_VALID by exactly 3 cycles.
